qea_host_ctrl: RTL and testbench

QEA_HOST_CTRL -- requirements
Module: qea_host_ctrl

---
 rtl/qea_host_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_qea_host_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qea_host_ctrl : loads gate context and state RAMs, runs the QEA, streams  |
// |                 the resulting state vector back to the host.              |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module qea_host_ctrl #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int CYC_WIDTH               = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
    input  logic                                 i_s_valid,
    output logic                                 o_s_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_s_data,
    output logic                                 o_m_valid,
    input  logic                                 i_m_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_m_data,
    output logic                                 o_qea_start,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [CYC_WIDTH-1:0]                 o_run_cycles
);

    localparam logic [2:0] c_idle       = 3'd0;
    localparam logic [2:0] c_load_ctx   = 3'd1;
    localparam logic [2:0] c_load_state = 3'd2;
    localparam logic [2:0] c_start      = 3'd3;
    localparam logic [2:0] c_run        = 3'd4;
    localparam logic [2:0] c_read       = 3'd5;

    localparam logic [MAX_QBIT_WIDTH-1:0] c_pe_shift = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] c_addr_w   = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH);

    logic [2:0]                           r_state;
    logic [2:0]                           w_state_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ins_num;
    logic [MAX_QBIT_WIDTH-1:0]            r_qbit_num;
    logic [STATE_ADDR_WIDTH-1:0]          r_state_last;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_cnt;
    logic [STATE_ADDR_WIDTH-1:0]          r_state_cnt;
    logic [STATE_ADDR_WIDTH-1:0]          r_rd_cnt;
    logic [STATE_ADDR_WIDTH-1:0]          r_beat_cnt;
    logic                                 r_rd_pend;
    logic                                 r_rd_done;
    logic                                 r_ctx_wr;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   r_ctx_addr;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   r_ctx_data;
    logic                                 r_state_wr;
    logic [STATE_ADDR_WIDTH-1:0]          r_state_addr;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   r_state_data;
    logic                                 r_m_valid;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0]   r_m_data;
    logic                                 r_done;
    logic [CYC_WIDTH-1:0]                 r_run_cycles;

    logic                                 w_s_fire;
    logic                                 w_m_fire;
    logic                                 w_rd_issue;
    logic [MAX_QBIT_WIDTH-1:0]            w_shift;
    logic [STATE_ADDR_WIDTH-1:0]          w_cmd_last;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   w_ctx_last;

    // Depth-1 of the state RAM, saturated to the full address range.
    assign w_shift    = (i_cmd_qbit_num > c_pe_shift) ? (i_cmd_qbit_num - c_pe_shift) : '0;
    assign w_cmd_last = (w_shift >= c_addr_w) ? '1 : ~({STATE_ADDR_WIDTH{1'b1}} << w_shift);
    assign w_ctx_last = r_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1);

    assign o_cmd_ready = (r_state == c_idle);
    assign o_s_ready   = (r_state == c_load_ctx) || (r_state == c_load_state);
    assign w_s_fire    = i_s_valid && o_s_ready;
    assign w_m_fire    = r_m_valid && i_m_ready;
    // Single outstanding read; only when the output register will be free on landing.
    assign w_rd_issue  = (r_state == c_read) && !r_rd_pend && !r_rd_done && (!r_m_valid || i_m_ready);

    assign o_qea_start   = (r_state == c_start);
    assign o_busy        = (r_state != c_idle);
    assign o_ctx_en      = r_ctx_wr;
    assign o_ctx_wea     = r_ctx_wr;
    assign o_ctx_addr    = r_ctx_addr;
    assign o_ctx_data    = r_ctx_data;
    assign o_state_ena   = r_state_wr || w_rd_issue;
    assign o_state_wea   = r_state_wr;
    assign o_state_addra = w_rd_issue ? r_rd_cnt : r_state_addr;
    assign o_state_dina  = r_state_data;
    assign o_m_valid     = r_m_valid;
    assign o_m_data      = r_m_data;
    assign o_qbit_num    = r_qbit_num;
    assign o_done        = r_done;
    assign o_run_cycles  = r_run_cycles;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:       if (i_cmd_valid) w_state_next = (i_cmd_ins_num != '0) ? c_load_ctx : c_load_state;
            c_load_ctx:   if (w_s_fire && (r_ctx_cnt == w_ctx_last)) w_state_next = c_load_state;
            c_load_state: if (w_s_fire && (r_state_cnt == r_state_last)) w_state_next = c_start;
            c_start:      w_state_next = c_run;
            c_run:        if ((r_run_cycles != '0) && i_qea_complete) w_state_next = c_read;
            c_read:       if (w_m_fire && (r_beat_cnt == r_state_last)) w_state_next = c_idle;
            default:      w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_ins_num    <= '0;
            r_qbit_num   <= '0;
            r_state_last <= '0;
            r_ctx_cnt    <= '0;
            r_state_cnt  <= '0;
            r_rd_cnt     <= '0;
            r_beat_cnt   <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_done    <= 1'b0;
            r_ctx_wr     <= 1'b0;
            r_ctx_addr   <= '0;
            r_ctx_data   <= '0;
            r_state_wr   <= 1'b0;
            r_state_addr <= '0;
            r_state_data <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ctx_wr   <= 1'b0;
            r_state_wr <= 1'b0;
            r_done     <= 1'b0;
            r_rd_pend  <= w_rd_issue;

            if ((r_state == c_idle) && i_cmd_valid) begin
                r_ins_num    <= i_cmd_ins_num;
                r_qbit_num   <= i_cmd_qbit_num;
                r_state_last <= w_cmd_last;
                r_ctx_cnt    <= '0;
                r_state_cnt  <= '0;
                r_rd_cnt     <= '0;
                r_beat_cnt   <= '0;
                r_rd_done    <= 1'b0;
            end

            if ((r_state == c_load_ctx) && w_s_fire) begin
                r_ctx_wr   <= 1'b1;
                r_ctx_addr <= r_ctx_cnt;
                r_ctx_data <= i_s_data[GATE_CONTEXT_DATA_WIDTH-1:0];
                r_ctx_cnt  <= (r_ctx_cnt == w_ctx_last) ? '0 : r_ctx_cnt + 1'b1;
            end

            if ((r_state == c_load_state) && w_s_fire) begin
                r_state_wr   <= 1'b1;
                r_state_addr <= r_state_cnt;
                r_state_data <= i_s_data;
                r_state_cnt  <= (r_state_cnt == r_state_last) ? '0 : r_state_cnt + 1'b1;
            end

            if (r_state == c_start) r_run_cycles <= '0;
            else if (r_state == c_run) r_run_cycles <= r_run_cycles + 1'b1;

            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (r_rd_cnt == r_state_last) r_rd_done <= 1'b1;
            end

            if (r_rd_pend) begin
                r_m_valid <= 1'b1;
                r_m_data  <= i_state_dout;
            end else if (w_m_fire) begin
                r_m_valid <= 1'b0;
            end

            if ((r_state == c_read) && w_m_fire) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (r_beat_cnt == r_state_last) r_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qea_host_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qea_host_ctrl : scoreboard bench for qea_host_ctrl with QEA/RAM model. |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_qea_host_ctrl;

    localparam int c_dw = 256;
    localparam int c_run_delay = 100;

    typedef struct {
        logic [15:0]     addr;
        logic [c_dw-1:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] run;
        logic [5:0]  qbit;
    } done_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_cmd_valid = 1'b0;
    logic            o_cmd_ready;
    logic [15:0]     i_cmd_ins_num = '0;
    logic [5:0]      i_cmd_qbit_num = '0;
    logic            i_s_valid = 1'b0;
    logic            o_s_ready;
    logic [c_dw-1:0] i_s_data = '0;
    logic            o_m_valid;
    logic            i_m_ready;
    logic [c_dw-1:0] o_m_data;
    logic            o_qea_start, o_ctx_en, o_ctx_wea;
    logic [15:0]     o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic            o_state_ena, o_state_wea;
    logic [15:0]     o_state_addra;
    logic [c_dw-1:0] o_state_dina;
    logic [5:0]      o_qbit_num;
    logic            i_qea_complete;
    logic [c_dw-1:0] i_state_dout;
    logic            o_busy, o_done;
    logic [31:0]     o_run_cycles;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int job_id = 0;
    bit rand_ready = 1'b0;

    wr_t             exp_ctx[$];
    wr_t             exp_st[$];
    logic [15:0]     exp_rd[$];
    logic [c_dw-1:0] exp_m[$];
    done_t           exp_done[$];
    logic [c_dw-1:0] ram [0:65535];

    qea_host_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ins_num(i_cmd_ins_num), .i_cmd_qbit_num(i_cmd_qbit_num),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data),
        .o_qea_start(o_qea_start), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
        .o_qbit_num(o_qbit_num), .i_qea_complete(i_qea_complete),
        .i_state_dout(i_state_dout),
        .o_busy(o_busy), .o_done(o_done), .o_run_cycles(o_run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [c_dw-1:0] mk_data(input int job, input int k);
        logic [c_dw-1:0] d;
        for (int l = 0; l < 4; l++)
            d[l*64 +: 64] = {job[7:0], l[7:0], k[15:0], 32'hA5A5_0000 ^ k[31:0]};
        return d;
    endfunction

    // State RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (o_state_ena && o_state_wea) ram[o_state_addra] <= o_state_dina;
        if (o_state_ena && !o_state_wea) i_state_dout <= ram[o_state_addra];
    end

    // QEA model: completes a fixed number of cycles after the start pulse.
    initial begin
        i_qea_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (o_qea_start) begin
                repeat (c_run_delay) @(negedge clk);
                i_qea_complete = 1'b1;
                @(negedge clk);
                i_qea_complete = 1'b0;
            end
        end
    end

    initial begin
        i_m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2 i_m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a strobe or beat.
    initial begin
        wr_t   w;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_ctx_en && o_ctx_wea) begin
                    if (exp_ctx.size() == 0) check("ctx_unexpected_write", 1'b1, 1'b0);
                    else begin
                        w = exp_ctx.pop_front();
                        check("ctx_addr", o_ctx_addr, w.addr);
                        check("ctx_data", o_ctx_data, w.data[63:0]);
                    end
                end
                if (o_state_ena && o_state_wea) begin
                    if (exp_st.size() == 0) check("state_unexpected_write", 1'b1, 1'b0);
                    else begin
                        w = exp_st.pop_front();
                        check("state_waddr", o_state_addra, w.addr);
                        check("state_wdata", o_state_dina, w.data);
                    end
                end
                if (o_state_ena && !o_state_wea) begin
                    if (exp_rd.size() == 0) check("state_unexpected_read", 1'b1, 1'b0);
                    else check("state_raddr", o_state_addra, exp_rd.pop_front());
                end
                if (o_m_valid && i_m_ready) begin
                    if (exp_m.size() == 0) check("m_unexpected_beat", 1'b1, 1'b0);
                    else check("m_data", o_m_data, exp_m.pop_front());
                end
                if (o_qea_start) start_cnt++;
                if (o_done) begin
                    if (exp_done.size() == 0) check("done_unexpected", 1'b1, 1'b0);
                    else begin
                        d = exp_done.pop_front();
                        check("run_cycles", o_run_cycles, d.run);
                        check("qbit_num", o_qbit_num, d.qbit);
                        check("start_pulses", start_cnt, 1);
                    end
                    start_cnt = 0;
                end
            end
        end
    end

    task automatic send_cmd(input int ins, input int qbit);
        int n = 0;
        int depth;
        @(posedge clk); #1;
        while (!o_cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
        check("cmd_ready_wait", o_cmd_ready, 1'b1);
        i_cmd_valid = 1'b1;
        i_cmd_ins_num = ins[15:0];
        i_cmd_qbit_num = qbit[5:0];
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        job_id++;
        depth = (qbit > 2) ? (1 << (qbit - 2)) : 1;
        for (int k = 0; k < ins; k++) exp_ctx.push_back('{k[15:0], mk_data(job_id, k)});
        for (int k = 0; k < depth; k++) begin
            exp_st.push_back('{k[15:0], mk_data(job_id, ins + k)});
            exp_rd.push_back(k[15:0]);
            exp_m.push_back(mk_data(job_id, ins + k));
        end
        exp_done.push_back('{32'(c_run_delay), qbit[5:0]});
    endtask

    task automatic send_beats(input int total, input bit gap);
        int n;
        for (int k = 0; k < total; k++) begin
            i_s_valid = 1'b1;
            i_s_data = mk_data(job_id, k);
            n = 0;
            while (!o_s_ready && n < 1000) begin @(posedge clk); #1; n++; end
            if (!o_s_ready) check("s_ready_wait", o_s_ready, 1'b1);
            @(posedge clk); #1;
            i_s_valid = 1'b0;
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 20000) begin @(negedge clk); n++; end
        check("done_seen", o_done, 1'b1);
        repeat (3) @(negedge clk);
        check("ctx_q_empty", exp_ctx.size(), 0);
        check("state_q_empty", exp_st.size(), 0);
        check("read_q_empty", exp_rd.size(), 0);
        check("m_q_empty", exp_m.size(), 0);
        check("done_q_empty", exp_done.size(), 0);
        check("busy_after_done", o_busy, 1'b0);
    endtask

    task automatic run_job(input int ins, input int qbit, input bit gap);
        int depth;
        depth = (qbit > 2) ? (1 << (qbit - 2)) : 1;
        send_cmd(ins, qbit);
        send_beats(ins + depth, gap);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_low", {o_ctx_en, o_state_ena, o_qea_start, o_m_valid, o_done, o_busy, o_s_ready}, '0);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", o_cmd_ready, 1'b1);
        check("rst_run_cycles", o_run_cycles, '0);
        check("rst_qbit_num", o_qbit_num, '0);

        run_job(3, 8, 1'b0);
        run_job(0, 2, 1'b0);
        run_job(2, 5, 1'b1);
        rand_ready = 1'b1;
        run_job(1, 8, 1'b0);
        rand_ready = 1'b0;

        // Abandon a job partway through the state load.
        send_cmd(1, 4);
        send_beats(3, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_strobes_low", {o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_qea_start}, '0);
        check("midrst_status_low", {o_m_valid, o_done, o_busy, o_s_ready}, '0);
        check("midrst_run_cycles", o_run_cycles, '0);
        check("midrst_qbit_num", o_qbit_num, '0);
        exp_ctx.delete(); exp_st.delete(); exp_rd.delete(); exp_m.delete(); exp_done.delete();
        start_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_cmd_ready", o_cmd_ready, 1'b1);
        run_job(2, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
